irow_filter: RTL and testbench

IROW_FILTER -- requirements
Module: irow_filter

---
 rtl/irow_filter.sv | 112 +++++++++++
 tb/tb_irow_filter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/irow_filter.sv
// Inverse reversible 5/3 lifting along one line: takes L/H coefficient pairs,
// emits reconstructed even/odd sample pairs with one pair of latency plus a flush.
module irow_filter (
  input  logic        clk_irf,
  input  logic        rst_syn,
  input  logic        ilu_work,
  input  logic [7:0]  row_len,
  input  logic [15:0] row_ldata,
  input  logic [15:0] row_hdata,
  input  logic        row_in_vld,
  output logic [15:0] even_data,
  output logic [15:0] odd_data,
  output logic        out_vld,
  output logic        line_done
);

  localparam int unsigned DW = 16;
  localparam int unsigned IW = 18;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        r_last;
  logic signed [IW-1:0] r_h;
  logic signed [IW-1:0] r_e;

  logic                 w_first;
  logic signed [IW-1:0] w_l;
  logic signed [IW-1:0] w_h;
  logic signed [IW-1:0] w_hprev;
  logic signed [IW-1:0] w_e;
  logic [DW-1:0]        w_odd_run;
  logic [DW-1:0]        w_odd_flush;
  logic [CW-1:0]        w_len_last;
  state_t               w_first_state;

  // Lifting datapath: e[k] from the incoming pair, o[k-1] from stored H/e.
  always_comb begin
    w_first       = (r_state != S_RUN);
    w_l           = {{(IW-DW){row_ldata[DW-1]}}, row_ldata};
    w_h           = {{(IW-DW){row_hdata[DW-1]}}, row_hdata};
    w_hprev       = w_first ? w_h : r_h;
    w_e           = w_l - ((w_hprev + w_h + IW'(2)) >>> 2);
    w_odd_run     = DW'(r_h + ((r_e + w_e) >>> 1));
    w_odd_flush   = DW'(r_h + r_e);
    w_len_last    = CW'(row_len - CW'(1));
    w_first_state = (w_len_last == '0) ? S_FLUSH : S_RUN;
  end

  // Line sequencing with registered outputs; disable behaves like reset.
  always_ff @(posedge clk_irf) begin
    if (!rst_syn || !ilu_work) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_last    <= '0;
      r_h       <= '0;
      r_e       <= '0;
      even_data <= '0;
      odd_data  <= '0;
      out_vld   <= 1'b0;
      line_done <= 1'b0;
    end else begin
      out_vld   <= 1'b0;
      line_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (row_in_vld) begin
            r_e     <= w_e;
            r_h     <= w_h;
            r_cnt   <= CW'(1);
            r_last  <= w_len_last;
            r_state <= w_first_state;
          end
        end
        S_RUN: begin
          if (row_in_vld) begin
            even_data <= r_e[DW-1:0];
            odd_data  <= w_odd_run;
            out_vld   <= 1'b1;
            r_e       <= w_e;
            r_h       <= w_h;
            if (r_cnt == r_last) begin
              r_state <= S_FLUSH;
            end else begin
              r_cnt <= CW'(r_cnt + CW'(1));
            end
          end
        end
        S_FLUSH: begin
          // Last pair uses e[N] = e[N-1]; a new line's pair 0 may load alongside.
          even_data <= r_e[DW-1:0];
          odd_data  <= w_odd_flush;
          out_vld   <= 1'b1;
          line_done <= 1'b1;
          if (row_in_vld) begin
            r_e     <= w_e;
            r_h     <= w_h;
            r_cnt   <= CW'(1);
            r_last  <= w_len_last;
            r_state <= w_first_state;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irow_filter.sv
// Directed self-checking bench for irow_filter with hand-computed lifting results.
module tb_irow_filter;

  logic        clk_irf = 1'b0;
  logic        rst_syn;
  logic        ilu_work;
  logic [7:0]  row_len;
  logic [15:0] row_ldata;
  logic [15:0] row_hdata;
  logic        row_in_vld;
  logic [15:0] even_data;
  logic [15:0] odd_data;
  logic        out_vld;
  logic        line_done;

  int n_total = 0;
  int n_pass  = 0;

  irow_filter dut (
    .clk_irf   (clk_irf),
    .rst_syn   (rst_syn),
    .ilu_work  (ilu_work),
    .row_len   (row_len),
    .row_ldata (row_ldata),
    .row_hdata (row_hdata),
    .row_in_vld(row_in_vld),
    .even_data (even_data),
    .odd_data  (odd_data),
    .out_vld   (out_vld),
    .line_done (line_done)
  );

  always #5 clk_irf = ~clk_irf;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic done,
                         input logic [15:0] ev, input logic [15:0] od);
    chk({tag, ".vld"}, 16'(out_vld), 16'(vld));
    chk({tag, ".done"}, 16'(line_done), 16'(done));
    chk({tag, ".even"}, even_data, ev);
    chk({tag, ".odd"}, odd_data, od);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".vld"}, 16'(out_vld), 16'd0);
    chk({tag, ".done"}, 16'(line_done), 16'd0);
  endtask

  // Apply inputs for one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic vld, input logic [7:0] len,
                      input logic [15:0] l, input logic [15:0] h);
    row_in_vld = vld;
    row_len    = len;
    row_ldata  = l;
    row_hdata  = h;
    @(posedge clk_irf);
    #1;
  endtask

  int vld_cnt;
  int done_cnt;

  initial begin
    rst_syn = 1'b0; ilu_work = 1'b1;
    step(1'b1, 8'd2, 16'd10, 16'd4);
    step(1'b0, 8'd0, 16'd0, 16'd0);
    chk_out("reset", 1'b0, 1'b0, 16'h0000, 16'h0000);
    rst_syn = 1'b1;
    step(1'b0, 8'd0, 16'd0, 16'd0);
    chk_idle("idle0");

    // N=2, L=(10,20), H=(4,-2)
    step(1'b1, 8'd2, 16'd10, 16'd4);
    chk_idle("n2.p0");
    step(1'b1, 8'd2, 16'd20, 16'hFFFE);
    chk_out("n2.o0", 1'b1, 1'b0, 16'd8, 16'd17);
    step(1'b0, 8'd0, 16'd0, 16'd0);
    chk_out("n2.o1", 1'b1, 1'b1, 16'd19, 16'd17);
    step(1'b0, 8'd0, 16'd0, 16'd0);
    chk_out("n2.hold", 1'b0, 1'b0, 16'd19, 16'd17);

    // N=1, L=5, H=3
    step(1'b1, 8'd1, 16'd5, 16'd3);
    chk_out("n1.acc", 1'b0, 1'b0, 16'd19, 16'd17);
    step(1'b0, 8'd0, 16'd0, 16'd0);
    chk_out("n1.o0", 1'b1, 1'b1, 16'd3, 16'd6);
    step(1'b0, 8'd0, 16'd0, 16'd0);
    chk_idle("n1.after");

    // Negative floor: L=(0,0), H=(-3,-3)
    step(1'b1, 8'd2, 16'd0, 16'hFFFD);
    step(1'b1, 8'd2, 16'd0, 16'hFFFD);
    chk_out("neg.o0", 1'b1, 1'b0, 16'd1, 16'hFFFE);
    step(1'b0, 8'd0, 16'd0, 16'd0);
    chk_out("neg.o1", 1'b1, 1'b1, 16'd1, 16'hFFFE);

    // Wrap: L=32767, H=-4
    step(1'b1, 8'd1, 16'h7FFF, 16'hFFFC);
    step(1'b0, 8'd0, 16'd0, 16'd0);
    chk_out("wrap", 1'b1, 1'b1, 16'h8001, 16'h7FFD);

    // Back-to-back: N=2 line, then N=1 pair 0 in the FLUSH cycle
    step(1'b1, 8'd2, 16'd10, 16'd4);
    step(1'b1, 8'd2, 16'd20, 16'hFFFE);
    chk_out("b2b.o0", 1'b1, 1'b0, 16'd8, 16'd17);
    step(1'b1, 8'd1, 16'd5, 16'd3);
    chk_out("b2b.o1", 1'b1, 1'b1, 16'd19, 16'd17);
    step(1'b0, 8'd0, 16'd0, 16'd0);
    chk_out("b2b.n1", 1'b1, 1'b1, 16'd3, 16'd6);
    step(1'b0, 8'd0, 16'd0, 16'd0);
    chk_idle("b2b.end");

    // Stall in RUN
    step(1'b1, 8'd2, 16'd10, 16'd4);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'd0, 16'd0, 16'd0);
      chk_idle("stall");
    end
    step(1'b1, 8'd2, 16'd20, 16'hFFFE);
    chk_out("stall.o0", 1'b1, 1'b0, 16'd8, 16'd17);
    step(1'b0, 8'd0, 16'd0, 16'd0);
    chk_out("stall.o1", 1'b1, 1'b1, 16'd19, 16'd17);

    // Reset mid-line of an N=4 line
    step(1'b1, 8'd4, 16'd1, 16'd1);
    rst_syn = 1'b0;
    step(1'b0, 8'd0, 16'd0, 16'd0);
    chk_out("rst.mid", 1'b0, 1'b0, 16'd0, 16'd0);
    rst_syn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'd0, 16'd0, 16'd0);
      chk_out("rst.quiet", 1'b0, 1'b0, 16'd0, 16'd0);
    end
    step(1'b1, 8'd2, 16'd10, 16'd4);
    step(1'b1, 8'd2, 16'd20, 16'hFFFE);
    chk_out("rst.o0", 1'b1, 1'b0, 16'd8, 16'd17);
    step(1'b0, 8'd0, 16'd0, 16'd0);
    chk_out("rst.o1", 1'b1, 1'b1, 16'd19, 16'd17);

    // ilu_work low mid-line: clears, ignores valid, no flush afterwards
    step(1'b1, 8'd2, 16'd10, 16'd4);
    ilu_work = 1'b0;
    step(1'b1, 8'd2, 16'd20, 16'hFFFE);
    chk_out("dis.clr", 1'b0, 1'b0, 16'd0, 16'd0);
    step(1'b1, 8'd1, 16'd5, 16'd3);
    step(1'b0, 8'd0, 16'd0, 16'd0);
    chk_out("dis.ign", 1'b0, 1'b0, 16'd0, 16'd0);
    ilu_work = 1'b1;
    step(1'b0, 8'd0, 16'd0, 16'd0);
    chk_idle("dis.noflush");

    // N=256 via row_len=0, L[n]=n, H[n]=0 -> e[n]=n, o[n]=n
    vld_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 8'd0, 16'(i), 16'd0);
      if (out_vld) vld_cnt++;
      if (line_done) done_cnt++;
    end
    chk("n256.vld_cnt", 16'(vld_cnt), 16'd255);
    chk("n256.done_cnt", 16'(done_cnt), 16'd0);
    chk_out("n256.o254", 1'b1, 1'b0, 16'd254, 16'd254);
    step(1'b0, 8'd0, 16'd0, 16'd0);
    chk_out("n256.o255", 1'b1, 1'b1, 16'd255, 16'd255);
    step(1'b0, 8'd0, 16'd0, 16'd0);
    chk_idle("n256.end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
